fwd_scoreboard: RTL and testbench



---
 rtl/fwd_scoreboard.sv | 112 +++++++++++
 tb/tb_fwd_scoreboard.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks in-flight producers (E..W) and resolves
// decode operands to forwarded data, a pending flag, or a stall.
// Ports: clk/reset (async, active-low); issue_* describe the decode
// instruction; rd_addr/rd_tuse/rf_data are per read port; res_data holds
// the stage results; fwd_data/fwd_pend are per port; stall and stall_cnt.
module fwd_scoreboard #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int STAGES = 3,
    parameter int NREAD  = 2,
    parameter int TW     = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     issue_valid,
    input  logic [REG_AW-1:0]        issue_dst,
    input  logic [TW-1:0]            issue_tnew,
    input  logic [NREAD*REG_AW-1:0]  rd_addr,
    input  logic [NREAD*TW-1:0]      rd_tuse,
    input  logic [NREAD*DATA_W-1:0]  rf_data,
    input  logic [STAGES*DATA_W-1:0] res_data,
    output logic [NREAD*DATA_W-1:0]  fwd_data,
    output logic [NREAD-1:0]         fwd_pend,
    output logic                     stall,
    output logic [15:0]              stall_cnt
);

    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][REG_AW-1:0] dst_q, dst_d;
    logic [STAGES-1:0][TW-1:0]     tnew_q, tnew_d;
    logic [15:0]                   stall_cnt_q, stall_cnt_d;
    logic [NREAD-1:0]              stall_req;

    always_comb begin : resolve
        logic              hit;
        logic [TW-1:0]     hit_tnew;
        logic [DATA_W-1:0] hit_data;
        logic [REG_AW-1:0] addr;
        logic [TW-1:0]     tuse;
        fwd_data  = rf_data;
        fwd_pend  = '0;
        stall_req = '0;
        hit       = 1'b0;
        hit_tnew  = '0;
        hit_data  = '0;
        addr      = '0;
        tuse      = '0;
        for (int p = 0; p < NREAD; p++) begin
            hit      = 1'b0;
            hit_tnew = '0;
            hit_data = '0;
            addr     = rd_addr[p*REG_AW +: REG_AW];
            tuse     = rd_tuse[p*TW +: TW];
            // Scan oldest to youngest so the youngest match wins.
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (valid_q[k] && dst_q[k] == addr && addr != '0) begin
                    hit      = 1'b1;
                    hit_tnew = tnew_q[k];
                    hit_data = res_data[k*DATA_W +: DATA_W];
                end
            end
            if (hit) begin
                if (hit_tnew == '0) begin
                    fwd_data[p*DATA_W +: DATA_W] = hit_data;
                end else if (hit_tnew <= tuse) begin
                    fwd_pend[p] = 1'b1;
                end else begin
                    stall_req[p] = 1'b1;
                end
            end
        end
    end

    assign stall     = issue_valid && (|stall_req);
    assign stall_cnt = stall_cnt_q;

    always_comb begin : shift
        valid_d     = '0;
        dst_d       = '0;
        tnew_d      = '0;
        stall_cnt_d = stall_cnt_q;
        // Entry 0 takes the decode instruction or a bubble.
        if (issue_valid && !stall) begin
            valid_d[0] = 1'b1;
            dst_d[0]   = issue_dst;
            tnew_d[0]  = issue_tnew;
        end
        for (int k = 1; k < STAGES; k++) begin
            valid_d[k] = valid_q[k-1];
            dst_d[k]   = dst_q[k-1];
            tnew_d[k]  = (tnew_q[k-1] == '0) ? '0 : tnew_q[k-1] - TW'(1);
        end
        if (stall && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q     <= '0;
            dst_q       <= '0;
            tnew_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            dst_q       <= dst_d;
            tnew_q      <= tnew_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed and random stimulus against an
// age-based producer model, plus a saturation run on a deep instance.
module tb_fwd_scoreboard;

    logic             clk;
    logic             rst_n;
    logic             iv;
    logic [4:0]       idst;
    logic [1:0]       itnew;
    logic [1:0][4:0]  ra;
    logic [1:0][1:0]  tuse;
    logic [1:0][31:0] rf;
    logic [2:0][31:0] res;
    logic [1:0][31:0] fwd;
    logic [1:0]       pend;
    logic             stall;
    logic [15:0]      cnt;

    logic              sat_rst_n;
    logic [9:0]        sat_addr;
    logic [63:0]       sat_fwd;
    logic [1:0]        sat_pend;
    logic              sat_stall;
    logic [15:0]       sat_cnt;

    int total = 0;
    int bad   = 0;

    fwd_scoreboard dut (
        .clk        (clk),
        .reset      (rst_n),
        .issue_valid(iv),
        .issue_dst  (idst),
        .issue_tnew (itnew),
        .rd_addr    (ra),
        .rd_tuse    (tuse),
        .rf_data    (rf),
        .res_data   (res),
        .fwd_data   (fwd),
        .fwd_pend   (pend),
        .stall      (stall),
        .stall_cnt  (cnt)
    );

    // Deep instance: a tnew=15 producer read with tuse=0 stalls 15 of
    // every 16 cycles, so saturation is reached in about 70k cycles.
    fwd_scoreboard #(.STAGES(16), .TW(4)) sat (
        .clk        (clk),
        .reset      (sat_rst_n),
        .issue_valid(1'b1),
        .issue_dst  (5'd3),
        .issue_tnew (4'd15),
        .rd_addr    (sat_addr),
        .rd_tuse    (8'd0),
        .rf_data    (64'd0),
        .res_data   (512'd0),
        .fwd_data   (sat_fwd),
        .fwd_pend   (sat_pend),
        .stall      (sat_stall),
        .stall_cnt  (sat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Model: each issued producer remembers the edge it entered E on;
    // its stage is its age in edges, its remaining latency tnew-age.
    typedef struct {
        logic [4:0] dst;
        int         tnew;
        int         edge_n;
    } rec_t;

    rec_t recs[$];
    int   n_edges = 0;
    int   m_cnt   = 0;

    logic [1:0][31:0] e_data;
    logic [1:0]       e_pend;
    logic             e_stall;

    task automatic model_eval();
        logic any_req;
        any_req = 1'b0;
        e_pend  = '0;
        for (int p = 0; p < 2; p++) begin
            bit found;
            int age;
            int rem;
            found     = 0;
            age       = 0;
            e_data[p] = rf[p];
            if (ra[p] != 5'd0) begin
                for (int i = recs.size() - 1; i >= 0; i--) begin
                    if (!found && recs[i].dst == ra[p]
                        && n_edges - recs[i].edge_n < 3) begin
                        found = 1;
                        age   = n_edges - recs[i].edge_n;
                        rem   = recs[i].tnew - age;
                        if (rem < 0) rem = 0;
                        if (rem == 0) e_data[p] = res[age];
                        else if (rem <= int'(tuse[p])) e_pend[p] = 1'b1;
                        else any_req = 1'b1;
                    end
                end
            end
        end
        e_stall = iv && any_req;
    endtask

    // Inputs are set after a negedge; check, then take one clock edge.
    task automatic cycle_chk();
        rec_t r;
        #1;
        model_eval();
        chk("fwd", fwd, e_data);
        chk("pend", pend, e_pend);
        chk("stall", stall, e_stall);
        chk("cnt", cnt, m_cnt);
        @(posedge clk);
        n_edges++;
        if (iv && !e_stall) begin
            r.dst    = idst;
            r.tnew   = itnew;
            r.edge_n = n_edges;
            recs.push_back(r);
        end
        if (e_stall && m_cnt < 16'hFFFF) m_cnt++;
        while (recs.size() > 0 && n_edges - recs[0].edge_n >= 3)
            void'(recs.pop_front());
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        iv = 1'b0;
        ra = '0;
        repeat (n) cycle_chk();
    endtask

    int c0;
    int m;
    logic [15:0] sat_exp;

    initial begin
        rst_n     = 1'b0;
        sat_rst_n = 1'b0;
        sat_addr  = {5'd3, 5'd3};
        iv        = 1'b0;
        idst      = '0;
        itnew     = '0;
        ra        = '0;
        tuse      = '0;
        rf        = {32'hAAAA_0001, 32'hAAAA_0000};
        res       = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 1'b0);
        chk("rst_pend", pend, 2'b00);
        chk("rst_cnt", cnt, 16'd0);
        rst_n = 1'b1;

        // First issue enters entry 0 on the next edge and is seen at once.
        iv = 1'b1; idst = 5'd8; itnew = 2'd0;
        cycle_chk();
        iv = 1'b0; ra[0] = 5'd8; tuse[0] = 2'd1; res[0] = 32'h1234;
        #1;
        chk("fwd_e0", fwd[0], 32'h1234);
        chk("fwd_e0_stall", stall, 1'b0);
        cycle_chk();
        idle(3);

        // Load-use: two stall cycles, then forward from W.
        c0 = m_cnt;
        iv = 1'b1; idst = 5'd9; itnew = 2'd2; ra = '0;
        cycle_chk();
        idst = 5'd0; ra[0] = 5'd9; tuse[0] = 2'd0;
        #1 chk("lu_stall1", stall, 1'b1);
        cycle_chk();
        #1 chk("lu_stall2", stall, 1'b1);
        cycle_chk();
        #1;
        chk("lu_go", stall, 1'b0);
        chk("lu_fwd_w", fwd[0], res[2]);
        chk("lu_cnt", cnt, 16'(c0 + 2));
        cycle_chk();
        idle(3);

        // Youngest match wins.
        iv = 1'b1; idst = 5'd5; itnew = 2'd0;
        cycle_chk();
        cycle_chk();
        iv = 1'b0; ra[0] = 5'd5; tuse[0] = 2'd0;
        res[0] = 32'hAB00_0000; res[1] = 32'hAB00_0001;
        #1 chk("young", fwd[0], 32'hAB00_0000);
        cycle_chk();
        idle(3);

        // Register zero never forwards, pends or stalls.
        iv = 1'b1; idst = 5'd0; itnew = 2'd2;
        cycle_chk();
        ra[0] = 5'd0; tuse[0] = 2'd0;
        #1;
        chk("r0_fwd", fwd[0], rf[0]);
        chk("r0_stall", stall, 1'b0);
        chk("r0_pend", pend[0], 1'b0);
        cycle_chk();
        idle(3);

        // Entry 1 with tnew=1 against tuse=1 pends.
        iv = 1'b1; idst = 5'd6; itnew = 2'd2;
        cycle_chk();
        iv = 1'b0;
        cycle_chk();
        iv = 1'b1; idst = 5'd0; ra[0] = 5'd6; tuse[0] = 2'd1;
        #1;
        chk("pend1", pend[0], 1'b1);
        chk("pend1_stall", stall, 1'b0);
        cycle_chk();
        idle(3);

        // Reset in the middle of a stall drops it at once.
        iv = 1'b1; idst = 5'd7; itnew = 2'd3;
        cycle_chk();
        idst = 5'd0; ra[0] = 5'd7; tuse[0] = 2'd0;
        #1 chk("mid_stall", stall, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 1'b0);
        chk("mid_rst_cnt", cnt, 16'd0);
        recs.delete();
        m_cnt   = 0;
        n_edges = 0;
        @(negedge clk);
        rst_n = 1'b1;
        iv = 1'b1; ra[0] = 5'd7; ra[1] = 5'd7; tuse = '0;
        #1 chk("post_rst_clear", {stall, pend}, 3'b000);
        idst = 5'd4; itnew = 2'd1;
        cycle_chk();
        idst = 5'd0; ra[0] = 5'd4;
        #1 chk("post_rst_issue", stall, 1'b1);
        cycle_chk();
        idle(3);

        for (int i = 0; i < 600; i++) begin
            iv    = ($urandom_range(0, 3) != 0);
            idst  = 5'($urandom_range(0, 7));
            itnew = 2'($urandom_range(0, 3));
            for (int p = 0; p < 2; p++) begin
                ra[p]   = 5'($urandom_range(0, 7));
                tuse[p] = 2'($urandom_range(0, 3));
                rf[p]   = $urandom;
            end
            for (int k = 0; k < 3; k++) res[k] = $urandom;
            cycle_chk();
        end

        chk("sat_rst_cnt", sat_cnt, 16'd0);
        sat_rst_n = 1'b1;
        m = 4368 * 16;
        repeat (m) @(posedge clk);
        @(negedge clk);
        sat_exp = 16'(m - (m + 15) / 16);
        chk("sat_near", sat_cnt, sat_exp);
        chk("sat_near_stall", sat_stall, 1'b0);
        repeat (32) @(posedge clk);
        m = m + 32;
        #1 chk("sat_hold", sat_cnt, 16'hFFFF);
        @(posedge clk);
        #1 chk("sat_hold2", sat_cnt, 16'hFFFF);
        chk("sat_stall", sat_stall, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
